// File: rtl/flat_array_serializer.sv
// flat_array_serializer: takes one flattened ROWS x COLS array over a
// valid/ready handshake and streams it out one element per beat, tagged
// with row/col indices and a last flag. Row index runs fastest, so beats
// follow the flat index k = col*ROWS + row in ascending order.
module flat_array_serializer #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROWS*COLS*BIT_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [BIT_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ROW_W-1:0]               out_row,
  output logic [COL_W-1:0]               out_col,
  output logic                           out_last
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                         state_q, state_d;
  logic [ROWS*COLS*BIT_WIDTH-1:0] arr_q;
  logic [ROW_W-1:0]               row_q;
  logic [COL_W-1:0]               col_q;
  logic                           row_end, col_end;
  logic                           accept, beat;

  // Counter end-of-range decode and handshake qualifiers
  always_comb begin
    row_end = (row_q == ROW_W'(ROWS - 1));
    col_end = (col_q == COL_W'(COLS - 1));
    accept  = in_valid && in_ready;
    beat    = out_valid && out_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a new array taken on the last beat keeps us streaming
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (beat && out_last) state_d = accept ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; in_ready looks through out_ready so arrays abut with no bubble
  always_comb begin
    out_valid = (state_q == STREAM);
    out_last  = out_valid && row_end && col_end;
    in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);
    out_row   = row_q;
    out_col   = col_q;
  end

  // Array buffer and element counters
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      arr_q <= in_data;
      row_q <= '0;
      col_q <= '0;
    end else if (beat) begin
      if (out_last) begin
        row_q <= '0;
        col_q <= '0;
      end else if (row_end) begin
        row_q <= '0;
        col_q <= col_q + 1'b1;
      end else begin
        row_q <= row_q + 1'b1;
      end
    end
  end

  // Element select on the registered counters
  always_comb begin
    out_data = '0;
    for (int unsigned j = 0; j < COLS; j++) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        if (row_q == ROW_W'(i) && col_q == COL_W'(j))
          out_data = arr_q[(j*ROWS + i)*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_flat_array_serializer.sv
// Directed bench for flat_array_serializer: a 2x3x4-bit instance for the
// streaming, backpressure, back-to-back and reset cases, and a 1x1x8-bit
// instance for the single-element case.
module tb_flat_array_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2x3 instance, 4-bit elements
  logic [23:0] a_in_data;
  logic        a_in_valid, a_in_ready;
  logic [3:0]  a_out_data;
  logic        a_out_valid, a_out_ready;
  logic [0:0]  a_out_row;
  logic [1:0]  a_out_col;
  logic        a_out_last;

  // 1x1 instance, 8-bit elements
  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_ready;
  logic [0:0]  b_out_row;
  logic [0:0]  b_out_col;
  logic        b_out_last;

  flat_array_serializer #(.BIT_WIDTH(4), .ROWS(2), .COLS(3)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_row(a_out_row), .out_col(a_out_col), .out_last(a_out_last)
  );

  flat_array_serializer #(.BIT_WIDTH(8), .ROWS(1), .COLS(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_row(b_out_row), .out_col(b_out_col), .out_last(b_out_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the 2x3 instance presents beat b (0..5) with data d
  task automatic beat_a(input string tag, input int b, input logic [3:0] d, input logic rdy);
    #1;
    chk({tag, "_valid"}, a_out_valid, 1);
    chk({tag, "_data"},  a_out_data, d);
    chk({tag, "_row"},   a_out_row, b % 2);
    chk({tag, "_col"},   a_out_col, b / 2);
    chk({tag, "_last"},  a_out_last, (b == 5));
    chk({tag, "_inrdy"}, a_in_ready, rdy);
  endtask

  task automatic idle_a(input string tag);
    #1;
    chk({tag, "_valid"}, a_out_valid, 0);
    chk({tag, "_inrdy"}, a_in_ready, 1);
    chk({tag, "_row"},   a_out_row, 0);
    chk({tag, "_col"},   a_out_col, 0);
    chk({tag, "_last"},  a_out_last, 0);
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    idle_a("rst");
    chk("rst_data", a_out_data, 0);

    // Single array, out_ready held high
    a_in_data = 24'h543210; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1 chk("t1_accept_rdy", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    for (int b = 0; b < 6; b++) begin
      beat_a("t1", b, 4'(b), (b == 5));
      step();
    end
    idle_a("t1_end");

    // Backpressure: stall 3 cycles on beats 2 and 4
    a_in_data = 24'h543210; a_in_valid = 1'b1; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int b = 0; b < 6; b++) begin
      if (b == 1 || b == 3) begin
        a_out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          beat_a("t2_stall", b, 4'(b), 1'b0);
          step();
        end
        a_out_ready = 1'b1;
      end
      beat_a("t2", b, 4'(b), (b == 5));
      step();
    end
    idle_a("t2_end");

    // Back-to-back: second array offered mid-stream, taken only on the last beat
    a_in_data = 24'h543210; a_in_valid = 1'b1; a_out_ready = 1'b1;
    step();
    a_in_data = 24'hBA9876;
    for (int b = 0; b < 6; b++) begin
      beat_a("t3_first", b, 4'(b), (b == 5));
      step();
    end
    a_in_valid = 1'b0;
    for (int b = 0; b < 6; b++) begin
      beat_a("t3_second", b, 4'(b + 6), (b == 5));
      step();
    end
    idle_a("t3_end");

    // Reset on the third beat discards the array
    a_in_data = 24'h543210; a_in_valid = 1'b1; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      beat_a("t4_pre", b, 4'(b), 1'b0);
      step();
    end
    beat_a("t4_b3", 2, 4'h2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_a("t4_rst");
    chk("t4_rst_data", a_out_data, 0);
    a_in_data = 24'hBA9876; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int b = 0; b < 6; b++) begin
      beat_a("t4_new", b, 4'(b + 6), (b == 5));
      step();
    end
    idle_a("t4_end");

    // 1x1 instance: back-to-back single-element arrays
    b_out_ready = 1'b1; b_in_data = 8'hA5; b_in_valid = 1'b1;
    #1 chk("t5_idle_valid", b_out_valid, 0);
    chk("t5_idle_rdy", b_in_ready, 1);
    step();
    b_in_data = 8'h3C;
    #1;
    chk("t5_a5_valid", b_out_valid, 1);
    chk("t5_a5_data",  b_out_data, 8'hA5);
    chk("t5_a5_last",  b_out_last, 1);
    chk("t5_a5_row",   b_out_row, 0);
    chk("t5_a5_col",   b_out_col, 0);
    chk("t5_a5_inrdy", b_in_ready, 1);
    step();
    b_in_valid = 1'b0;
    #1;
    chk("t5_3c_valid", b_out_valid, 1);
    chk("t5_3c_data",  b_out_data, 8'h3C);
    chk("t5_3c_last",  b_out_last, 1);
    chk("t5_3c_row",   b_out_row, 0);
    chk("t5_3c_col",   b_out_col, 0);
    step();
    #1;
    chk("t5_end_valid", b_out_valid, 0);
    chk("t5_end_inrdy", b_in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
